// File: rtl/psa_pkg.sv
// Shared types and constants for the serial 4-lane packed add/subtract unit.
package psa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANE_W  = 4;
  localparam int N_LANES = 4;

  // Clamp values for a signed 4-bit lane
  localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

endpackage

// File: rtl/psub_serial_16bit_if.sv
// Operation bus of psub_serial_16bit.
//
// Handshake: the requester raises start with op/A/B valid; the unit samples
// them only while idle (busy=0) on a rising edge. busy then stays high until
// the unit returns to idle. done pulses for exactly one cycle when
// result/ovfl/error are complete; those values then hold until the next
// accepted start. start while busy is ignored.
interface psub_serial_16bit_if;
  logic        start;
  logic        op;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  ovfl;
  logic        error;

  modport master (
    output start, op, A, B,
    input  busy, done, result, ovfl, error
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, ovfl, error
  );
endinterface

// File: rtl/lane_addsub_4bit.sv
// One signed 4-bit lane adder/subtractor with signed-overflow detection.
module lane_addsub_4bit
  import psa_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  output logic [LANE_W-1:0] s,
  output logic              ovfl
);

  localparam int MSB = LANE_W - 1;

  logic [LANE_W-1:0] b_eff;

  // Subtract as a + ~b + 1; the carry-in is the sub flag itself
  always_comb begin
    b_eff = sub ? ~b : b;
    s     = a + b_eff + {{(LANE_W-1){1'b0}}, sub};
    if (sub) ovfl = (a[MSB] != b[MSB]) && (s[MSB] != a[MSB]);
    else     ovfl = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
  end

endmodule

// File: rtl/psub_serial_16bit.sv
// Serial packed SIMD add/subtract: four signed 4-bit lanes processed one
// per cycle, LSB lane first, through a single shared lane unit.
module psub_serial_16bit
  import psa_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  psub_serial_16bit_if.slave   bus,
  output state_t               dbg_state_o
);

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [15:0]       a_q;
  logic [15:0]       b_q;
  logic              op_q;
  logic [15:0]       result_q;
  logic [3:0]        ovfl_q;
  logic              busy_q;
  logic              done_q;

  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W-1:0] lane_s;
  logic              lane_ovfl;
  logic [LANE_W-1:0] lane_res_d;

  // Select the lane addressed by the counter from the captured operands
  always_comb begin
    lane_a = a_q[{cnt_q, 2'b00} +: LANE_W];
    lane_b = b_q[{cnt_q, 2'b00} +: LANE_W];
  end

  lane_addsub_4bit u_lane (
    .a    (lane_a),
    .b    (lane_b),
    .sub  (op_q),
    .s    (lane_s),
    .ovfl (lane_ovfl)
  );

  // Optional clamp: the overflow direction follows the sign of operand a
  always_comb begin
    lane_res_d = lane_s;
    if (SATURATE && lane_ovfl) lane_res_d = lane_a[LANE_W-1] ? SAT_NEG : SAT_POS;
  end

  // Control FSM with registered outputs and per-lane result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      ovfl_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            op_q     <= bus.op;
            result_q <= '0;
            ovfl_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q[{cnt_q, 2'b00} +: LANE_W] <= lane_res_d;
          ovfl_q[cnt_q]                      <= lane_ovfl;
          cnt_q                              <= cnt_q + 2'd1;
          if (cnt_q == 2'(N_LANES - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Drive the bus; error is a pure OR of the overflow register
  always_comb begin
    bus.busy    = busy_q;
    bus.done    = done_q;
    bus.result  = result_q;
    bus.ovfl    = ovfl_q;
    bus.error   = |ovfl_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_psub_serial_16bit.sv
// Bench for psub_serial_16bit: wrap and saturate instances share stimulus.
module tb_psub_serial_16bit;
  import psa_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        start;
  logic        op;
  logic [15:0] A;
  logic [15:0] B;

  psub_serial_16bit_if bus0 ();
  psub_serial_16bit_if bus1 ();
  state_t dbg0, dbg1;

  assign bus0.start = start;
  assign bus0.op    = op;
  assign bus0.A     = A;
  assign bus0.B     = B;
  assign bus1.start = start;
  assign bus1.op    = op;
  assign bus1.A     = A;
  assign bus1.B     = B;

  psub_serial_16bit #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state_o(dbg0));
  psub_serial_16bit #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state_o(dbg1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Signed integer arithmetic per lane, then wrap or clamp.
  function automatic void model_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                                   input bit sat, output logic [15:0] r, output logic [3:0] v);
    int sa, sb, sum;
    logic [3:0] la, lb;
    r = '0;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      la  = a[4*i +: 4];
      lb  = b[4*i +: 4];
      sa  = la[3] ? int'(la) - 16 : int'(la);
      sb  = lb[3] ? int'(lb) - 16 : int'(lb);
      sum = o ? sa - sb : sa + sb;
      v[i] = (sum > 7) || (sum < -8);
      if (v[i] && sat) r[4*i +: 4] = (sum > 7) ? 4'h7 : 4'h8;
      else             r[4*i +: 4] = 4'(sum);
    end
  endfunction

  // m_age: 0 idle, 1..4 edges since accept (lanes written = m_age-1 before
  // this edge), 5 = done cycle.
  int          m_age;
  int          m_lanes;
  logic [15:0] m_full0, m_full1;
  logic [3:0]  m_ovf;
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age   = 0;
      m_lanes = 0;
      m_full0 = '0;
      m_full1 = '0;
      m_ovf   = '0;
      exp_q.delete();
    end else if (m_age == 0) begin
      if (start) begin
        model_op(op, A, B, 1'b0, m_full0, m_ovf);
        model_op(op, A, B, 1'b1, m_full1, m_ovf);
        exp_q.push_back({m_full1, m_full0});
        m_lanes = 0;
        m_age   = 1;
      end
    end else if (m_age < 5) begin
      m_lanes = m_age;
      m_age++;
    end else begin
      m_age = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    logic [15:0] mask;
    logic [3:0]  omask;
    logic [31:0] head;
    #1;
    mask  = (m_lanes >= 4) ? 16'hFFFF : 16'((32'h1 << (4 * m_lanes)) - 1);
    omask = 4'((8'h1 << m_lanes) - 1);
    chk("busy0",   32'(bus0.busy), 32'(m_age != 0));
    chk("busy1",   32'(bus1.busy), 32'(m_age != 0));
    chk("done0",   32'(bus0.done), 32'(m_age == 5));
    chk("done1",   32'(bus1.done), 32'(m_age == 5));
    chk("result0", 32'(bus0.result), 32'(m_full0 & mask));
    chk("result1", 32'(bus1.result), 32'(m_full1 & mask));
    chk("ovfl0",   32'(bus0.ovfl), 32'(m_ovf & omask));
    chk("ovfl1",   32'(bus1.ovfl), 32'(m_ovf & omask));
    chk("error0",  32'(bus0.error), 32'(|(m_ovf & omask)));
    chk("state0",  32'(dbg0), (m_age == 0) ? 32'(IDLE) : (m_age == 5) ? 32'(DONE) : 32'(RUN));
    chk("state1",  32'(dbg1), (m_age == 0) ? 32'(IDLE) : (m_age == 5) ? 32'(DONE) : 32'(RUN));
    if (bus0.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_no_op: got done=1 expected no pending operation at %0t", $time);
      end else begin
        head = exp_q.pop_front();
        chk("q_result0", 32'(bus0.result), 32'(head[15:0]));
        chk("q_result1", 32'(bus1.result), 32'(head[31:16]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!bus0.done && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        A  = 16'($urandom);
        B  = 16'($urandom);
        op = 1'($urandom_range(0, 1));
      end
    end
    chk(name, n, exp_lat);
  endtask

  task automatic run_op(input string name, input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r0, input logic [3:0] v0, input logic [15:0] r1);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    wait_done({name, "_latency"}, 4);
    chk({name, "_r0"},  32'(bus0.result), 32'(r0));
    chk({name, "_ov"},  32'(bus0.ovfl),   32'(v0));
    chk({name, "_err"}, 32'(bus0.error),  32'(|v0));
    chk({name, "_r1"},  32'(bus1.result), 32'(r1));
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(bus0.busy), 32'(0));
    repeat (2) @(negedge clk);
    chk({name, "_hold"}, 32'(bus0.result), 32'(r0));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(bus0.result), 32'(0));
    chk("rst_busy",   32'(bus0.busy),   32'(0));
    chk("rst_done",   32'(bus0.done),   32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add",      1'b0, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 16'h2345);
    run_op("add_ovf",  1'b0, 16'h7000, 16'h1000, 16'h8000, 4'b1000, 16'h7000);
    run_op("sub",      1'b1, 16'h5432, 16'h1111, 16'h4321, 4'b0000, 16'h4321);
    run_op("sub_ovf",  1'b1, 16'h8000, 16'h1000, 16'h7000, 4'b1000, 16'h8000);
    run_op("add_zero", 1'b0, 16'hFFFF, 16'h1111, 16'h0000, 4'b0000, 16'h0000);
    run_op("add_neg",  1'b0, 16'h8888, 16'h8888, 16'h0000, 4'b1111, 16'h8888);
    run_op("sub_pos",  1'b1, 16'h7777, 16'h8888, 16'hFFFF, 4'b1111, 16'h7777);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; A = 16'h1111; B = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_latency", 2);
    chk("busy_r0", 32'(bus0.result), 32'h2222);
    chk("busy_r1", 32'(bus1.result), 32'h2222);
    @(negedge clk);
    chk("busy_low_after", 32'(bus0.busy), 32'(0));
    repeat (2) @(negedge clk);

    // reset after lane 1 is written
    start = 1'b1; op = 1'b0; A = 16'h5555; B = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_partial", 32'(bus0.result), 32'h0066);
    rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(bus0.result), 32'(0));
    chk("arst_busy",   32'(bus0.busy),   32'(0));
    chk("arst_state",  32'(dbg0),        32'(IDLE));
    repeat (2) @(negedge clk);
    chk("arst_nodone", 32'(bus0.done), 32'(0));
    rst_n = 1'b1;
    run_op("after_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 16'h0002);

    repeat (3) @(negedge clk);
    chk("q_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psub_serial_16bit.md
PSUB_SERIAL_16BIT -- requirements
Module: psub_serial_16bit

Interface
REQ-001 Parameter SATURATE, default 0, meaning: 0 = lanes wrap on overflow, 1 = lanes clamp to signed 4-bit limits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  1  0 = lane-wise add A+B, 1 = lane-wise subtract A-B.
REQ-006 A  input  16  operand A: four signed 4-bit lanes; lane i = A[4i+3:4i].
REQ-007 B  input  16  operand B, same lane layout as A.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result, ovfl and error are valid.
REQ-010 result  output  16  lane-wise sum or difference.
REQ-011 ovfl  output  4  per-lane signed overflow flags; bit i belongs to lane i.
REQ-012 error  output  1  OR of ovfl[3:0].

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture A, B and op into internal registers, clear result and ovfl, set lane counter to 0, and go to RUN.
REQ-015 In RUN, each rising edge SHALL compute lane[cnt] from the captured operands, write result and ovfl bit for lane[cnt], and increment cnt.
- Lanes are processed LSB first, one per cycle.
REQ-016 The RUN edge that processes lane 3 SHALL move the state to DONE; cnt wraps to 0.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return to IDLE.
REQ-018 Timing: start accepted at edge k -> lanes 0..3 written at edges k+1..k+4 -> done high between edges k+4 and k+5.
REQ-019 Lane add SHALL compute s = a+b (4-bit); ovfl = (a[3]==b[3]) && (s[3]!=a[3]).
REQ-020 Lane subtract SHALL compute s = a + ~b + 1 (4-bit); ovfl = (a[3]!=b[3]) && (s[3]!=a[3]).
REQ-021 With SATURATE=1 and lane ovfl=1, the lane result SHALL be 4'h7 if a[3]=0, else 4'h8. With SATURATE=0 the wrapped s SHALL be kept.
REQ-022 result, ovfl and error SHALL hold their values after DONE until the next accepted start.
REQ-023 start in RUN or DONE SHALL be ignored with no effect on the operation in progress. A, B and op changes after capture SHALL have no effect.
REQ-024 error SHALL be combinational from the ovfl register.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, cnt=0, result=16'h0000, ovfl=4'h0, error=0, busy=0, done=0, and clear the captured operands.
REQ-026 Reset during RUN or DONE SHALL abort the operation: no done pulse, and the next start behaves as from power-up.

Structure
REQ-027 Package psa_pkg SHALL hold:
- state enum {IDLE, RUN, DONE}
- LANE_W=4 and N_LANES=4
- SAT_POS=4'h7 and SAT_NEG=4'h8
REQ-028 One combinational sub-module, lane_addsub_4bit (a, b, sub -> s, ovfl), SHALL be instantiated once and muxed by cnt.

Verification
REQ-029 Add: op=0, A=16'h1234, B=16'h1111 -> result=16'h2345, ovfl=4'b0000, error=0; done exactly 4 cycles after the start edge.
REQ-030 Add overflow: op=0, A=16'h7000, B=16'h1000 -> SATURATE=0: result=16'h8000, ovfl=4'b1000, error=1; SATURATE=1: result=16'h7000.
REQ-031 Subtract:
- op=1, A=16'h5432, B=16'h1111 -> result=16'h4321, error=0.
- op=1, A=16'h8000, B=16'h1000 -> SATURATE=0: 16'h7000, ovfl=4'b1000; SATURATE=1: 16'h8000.
REQ-032 Start while busy: start op=0 A=16'h1111 B=16'h1111, then start at edge k+2 with A=16'hFFFF B=16'hFFFF -> single done, result=16'h2222; busy low one cycle after done.
REQ-033 Reset mid-run: rst_n low after lane 1 is written -> all outputs 0 asynchronously, no done. A new start with A=16'h0001, B=16'h0001 -> result=16'h0002 after 4 cycles.
